// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Shares one external hex decoder, registers the drive lines, and loads values tear-free at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic                  ack,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [3:0]            dec_bin,
  input  logic [6:0]            dec_seg,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned PCNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned DISP_W = 4 * DIGITS;

  typedef enum logic {ST_OFF = 1'b0, ST_SCAN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic frame_end_c;
  logic capture_c;
  logic lz_blank_c;
  logic [3:0] nib_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      pcnt_q  <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (en)  state_d = ST_SCAN;
      ST_SCAN: if (!en) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  assign frame_end_c = (state_q == ST_SCAN) &&
                       (pcnt_q == PCNT_W'(REFRESH_DIV - 1)) &&
                       (idx_q == IDX_W'(DIGITS - 1));
  assign capture_c   = load && ((state_q == ST_OFF) || frame_end_c);
  assign nib_c       = disp_q[{idx_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant nibble are zero
  always_comb begin
    logic all_zero;
    logic hit;
    all_zero = 1'b1;
    hit      = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) hit = all_zero;
    end
    lz_blank_c = blank_lz && (idx_q != '0) && hit;
  end

  // Counters, shadow load and drive-line outputs
  always_comb begin
    pcnt_d = '0;
    idx_d  = '0;
    disp_d = disp_q;
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (capture_c) disp_d = value;
    if ((state_q == ST_SCAN) && en) begin
      if (pcnt_q == PCNT_W'(REFRESH_DIV - 1)) begin
        pcnt_d = '0;
        idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
        idx_d  = idx_q;
      end
      an_d = (pcnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);
      if (!lz_blank_c) begin
        // the shared decoder blanks 4'h0, so the zero glyph is forced here
        seg_d = (nib_c == 4'h0) ? 7'b1000000 : dec_seg;
        dp_d  = ~dp_mask[idx_q];
      end
    end
  end

  assign dec_bin    = nib_c;
  assign ack        = capture_c && !rst;
  assign frame_tick = frame_end_c && !rst;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

endmodule
